// File: rtl/exception_pc_unit.sv
// exception_pc_unit: multicycle exception entry / eret sequencer.
// On an exception request it saves PC-4 into EPC, reads the one-byte
// handler address from the vector table and then loads the handler into
// the PC. On eret it loads EPC back into the PC. busy stalls main control
// for the whole sequence.
//
// Optional feature macro: EXC_CAUSE_REG_EN
//   defined   -> cause register implemented; cause holds from SAVE until RET
//   undefined -> cause output tied to 2'b00. The vector offset still comes
//                from the priority encoding captured on the request edge.
//
// Handshake note: there is no valid/ready pair here. Requests are level
// samples taken only in IDLE; memory is a fixed-latency read where mem_req
// marks the READ window and mem_data is sampled at the final READ edge only.
// All outputs are registers or decodes of the state register.
module exception_pc_unit #(
  parameter int MEM_LATENCY = 2,
  parameter int VEC_BASE    = 253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        opcode_invalid,
  input  logic        overflow,
  input  logic        div_zero,
  input  logic        eret,
  input  logic [7:0]  mem_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] epc,
  output logic [31:0] vector_pc,
  output logic [1:0]  pc_source,
  output logic        pc_write,
  output logic        busy,
  output logic [1:0]  cause,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SAVE = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_LOAD = 3'd3;
  localparam logic [2:0] S_RET  = 3'd4;

  localparam logic [2:0]  LAT_INIT   = 3'(MEM_LATENCY - 1);
  localparam logic [31:0] VEC_BASE_W = 32'(VEC_BASE);

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] vec_q, vec_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  code_q, code_d;

  logic        req_any;
  logic [1:0]  req_code;

  // Priority encode the exception requests: opcode_invalid > overflow > div_zero.
  always_comb begin
    req_any  = opcode_invalid | overflow | div_zero;
    req_code = 2'd0;
    if (opcode_invalid)  req_code = 2'd1;
    else if (overflow)   req_code = 2'd2;
    else if (div_zero)   req_code = 2'd3;
  end

  // Next-state and datapath capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    vec_d   = vec_q;
    addr_d  = addr_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        // Exceptions win over a simultaneous eret; lower-priority requests drop.
        if (req_any) begin
          state_d = S_SAVE;
          code_d  = req_code;
        end else if (eret) begin
          state_d = S_RET;
`ifdef EXC_CAUSE_REG_EN
          code_d  = 2'd0;
`endif
        end
      end
      S_SAVE: begin
        epc_d   = pc - 32'd4;
        addr_d  = VEC_BASE_W + {30'd0, code_q} - 32'd1;
        cnt_d   = LAT_INIT;
        state_d = S_READ;
      end
      S_READ: begin
        if (cnt_q == 3'd0) begin
          vec_d   = {{24{mem_data[7]}}, mem_data};
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_LOAD:  state_d = S_IDLE;
      S_RET:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sequence without a PC write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      epc_q   <= 32'd0;
      vec_q   <= 32'd0;
      addr_q  <= 32'd0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      vec_q   <= vec_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
    end
  end

  assign mem_req   = (state_q == S_READ);
  assign pc_write  = (state_q == S_LOAD) || (state_q == S_RET);
  assign pc_source = (state_q == S_LOAD) ? 2'b11 :
                     (state_q == S_RET)  ? 2'b01 : 2'b00;
  assign busy      = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign epc       = epc_q;
  assign vector_pc = vec_q;
  assign dbg_state = state_q;

`ifdef EXC_CAUSE_REG_EN
  assign cause = code_q;
`else
  assign cause = 2'b00;
`endif

endmodule

// File: tb/tb_exception_pc_unit.sv
// Testbench for exception_pc_unit: directed table, reset corner case and
// random transactions checked against a cycle-timeline reference model.
module tb_exception_pc_unit;

  localparam int L  = 2;
  localparam int VB = 253;
`ifdef EXC_CAUSE_REG_EN
  localparam bit CREG = 1'b1;
`else
  localparam bit CREG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        opcode_invalid, overflow, div_zero, eret;
  logic [7:0]  mem_data;
  logic        mem_req;
  logic [31:0] mem_addr, epc, vector_pc;
  logic [1:0]  pc_source;
  logic        pc_write, busy;
  logic [1:0]  cause;
  logic [2:0]  dbg_state;

  exception_pc_unit #(.MEM_LATENCY(L), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .opcode_invalid(opcode_invalid), .overflow(overflow),
    .div_zero(div_zero), .eret(eret), .mem_data(mem_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .epc(epc),
    .vector_pc(vector_pc), .pc_source(pc_source), .pc_write(pc_write),
    .busy(busy), .cause(cause), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected control word per cycle: {busy, mem_req, pc_write, pc_source}
  logic [4:0] exp_q[$];

  // Model of the architecturally visible held values
  logic [31:0] m_epc, m_vec, m_addr;
  logic [1:0]  m_cause;

  typedef struct {
    logic        opi, ovf, dz, er;
    logic [31:0] pc_v;
    logic [7:0]  b;
    bit          noise;
    logic [31:0] e_epc, e_addr, e_vec;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t tbl[4];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_epc = 32'd0; m_vec = 32'd0; m_addr = 32'd0; m_cause = 2'd0;
  endtask

  task automatic check_held(input string tag);
    check32({tag, " epc"}, epc, m_epc);
    check32({tag, " vector_pc"}, vector_pc, m_vec);
    check32({tag, " mem_addr"}, mem_addr, m_addr);
    check32({tag, " cause"}, {30'd0, cause}, {30'd0, m_cause});
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, " ctrl"}, {27'd0, busy, mem_req, pc_write, pc_source}, 32'd0);
    check32({tag, " epc"}, epc, 32'd0);
    check32({tag, " vector_pc"}, vector_pc, 32'd0);
    check32({tag, " mem_addr"}, mem_addr, 32'd0);
    check32({tag, " cause"}, {30'd0, cause}, 32'd0);
  endtask

  // One transaction: inputs presented for one edge, then the full timeline checked.
  task automatic run_txn(input logic opi, input logic ovf, input logic dz, input logic er,
                         input logic [31:0] pc_v, input logic [7:0] byte_v, input bit noise);
    int len;
    logic [1:0] c;
    logic [4:0] w, act;
    c = opi ? 2'd1 : ovf ? 2'd2 : dz ? 2'd3 : 2'd0;
    exp_q.delete();
    if (c != 2'd0) begin
      exp_q.push_back(5'b10000);
      for (int i = 0; i < L; i++) exp_q.push_back(5'b11000);
      exp_q.push_back(5'b10111);
      m_epc   = pc_v - 32'd4;
      m_addr  = 32'(VB) + 32'(c) - 32'd1;
      m_vec   = {{24{byte_v[7]}}, byte_v};
      m_cause = CREG ? c : 2'd0;
    end else if (er) begin
      exp_q.push_back(5'b10101);
      m_cause = 2'd0;
    end
    exp_q.push_back(5'b00000);
    len = exp_q.size();

    opcode_invalid = opi; overflow = ovf; div_zero = dz; eret = er;
    pc = pc_v;
    mem_data = 8'($urandom);
    for (int k = 0; k < len; k++) begin
      tick();
      w   = exp_q.pop_front();
      act = {busy, mem_req, pc_write, pc_source};
      n_tests++;
      if (act !== w) begin
        n_fail++;
        $display("FAIL ctrl[%0d] {busy,mem_req,pc_write,pc_source}: got %b expected %b", k, act, w);
      end
      opcode_invalid = 1'b0; overflow = 1'b0; div_zero = 1'b0; eret = 1'b0;
      if (noise && k < len - 1) begin
        opcode_invalid = 1'($urandom_range(0, 1));
        overflow       = 1'($urandom_range(0, 1));
        div_zero       = 1'($urandom_range(0, 1));
        eret           = 1'($urandom_range(0, 1));
      end
      mem_data = (c != 2'd0 && k == L) ? byte_v : 8'($urandom);
    end
    check_held("txn");
  endtask

  initial begin
    // Directed vectors
    tbl[0] = '{opi:0, ovf:1, dz:0, er:0, pc_v:32'h0000_0108, b:8'h84, noise:0,
               e_epc:32'h0000_0104, e_addr:32'd254, e_vec:32'hFFFF_FF84, e_cause:(CREG ? 2'd2 : 2'd0)};
    tbl[1] = '{opi:1, ovf:1, dz:0, er:1, pc_v:32'h0000_1000, b:8'h10, noise:0,
               e_epc:32'h0000_0FFC, e_addr:32'd253, e_vec:32'h0000_0010, e_cause:(CREG ? 2'd1 : 2'd0)};
    tbl[2] = '{opi:0, ovf:0, dz:0, er:1, pc_v:32'h0000_2222, b:8'hAA, noise:0,
               e_epc:32'h0000_0FFC, e_addr:32'd253, e_vec:32'h0000_0010, e_cause:2'd0};
    tbl[3] = '{opi:0, ovf:0, dz:1, er:0, pc_v:32'h0000_0000, b:8'h7F, noise:1,
               e_epc:32'hFFFF_FFFC, e_addr:32'd255, e_vec:32'h0000_007F, e_cause:(CREG ? 2'd3 : 2'd0)};

    // Reset
    reset = 1'b1;
    pc = 32'd0; opcode_invalid = 1'b0; overflow = 1'b0; div_zero = 1'b0; eret = 1'b0;
    mem_data = 8'd0;
    model_reset();
    tick(); tick();
    check_reset_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_txn(tbl[i].opi, tbl[i].ovf, tbl[i].dz, tbl[i].er, tbl[i].pc_v, tbl[i].b, tbl[i].noise);
      check32($sformatf("tbl[%0d] epc", i), epc, tbl[i].e_epc);
      check32($sformatf("tbl[%0d] mem_addr", i), mem_addr, tbl[i].e_addr);
      check32($sformatf("tbl[%0d] vector_pc", i), vector_pc, tbl[i].e_vec);
      check32($sformatf("tbl[%0d] cause", i), {30'd0, cause}, {30'd0, tbl[i].e_cause});
    end

    // Reset asserted asynchronously mid-READ aborts the sequence
    overflow = 1'b1; pc = 32'h0000_5000;
    tick();                     // SAVE
    overflow = 1'b0;
    tick();                     // READ
    check32("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async reset");
    tick();
    check_reset_outputs("held reset");
    reset = 1'b0;
    model_reset();
    tick();
    check32("post-reset idle ctrl", {27'd0, busy, mem_req, pc_write, pc_source}, 32'd0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0108, 8'h84, 1'b0);
    check32("post-reset epc", epc, 32'h0000_0104);
    check32("post-reset vector_pc", vector_pc, 32'hFFFF_FF84);

    // Random transactions
    for (int r = 0; r < 60; r++) begin
      logic [2:0] rq;
      rq = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rq = 3'd0;
      run_txn(rq[2], rq[1], rq[0], 1'($urandom_range(0, 1)),
              $urandom, 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time bound");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
